// File: rtl/alu_iter.sv
// Iterative 32-bit ALU with valid/ready handshakes; SLL and CTZ run multi-cycle.
// Define ALU_ITER_FAST_SHIFT_EN to make SLL a single-cycle operation.
module alu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_ctl,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_CTZ = 4'b1010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [5:0]       count, count_n;
   logic [WIDTH-1:0] shadow, shadow_n;
   logic [WIDTH-1:0] res_q, res_n;
   logic [4:0]       shamt, shamt_n;
   logic             is_ctz, is_ctz_n;
   logic             iter_op;

   function automatic logic [WIDTH-1:0] comb_op(
      input logic [3:0]       ctl,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b
   );
      logic [WIDTH-1:0] r;
      r = '0;
      case (ctl)
         OP_ADD: r = a + b;
         OP_SUB: r = a - b;
         OP_SLT: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_OR:  r = a | b;
         OP_AND: r = a & b;
`ifdef ALU_ITER_FAST_SHIFT_EN
         OP_SLL: r = a << b[4:0];
`endif
         default: r = '0;
      endcase
      return r;
   endfunction

   // Which opcodes take the iterative BUSY path in this build
`ifdef ALU_ITER_FAST_SHIFT_EN
   assign iter_op = (alu_ctl == OP_CTZ);
`else
   assign iter_op = (alu_ctl == OP_CTZ) || (alu_ctl == OP_SLL);
`endif

   // Next-state and datapath update; every register holds unless changed
   always_comb begin
      state_n  = state;
      count_n  = count;
      shadow_n = shadow;
      res_n    = res_q;
      shamt_n  = shamt;
      is_ctz_n = is_ctz;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (iter_op) begin
                  state_n  = BUSY;
                  count_n  = '0;
                  shadow_n = op_a;
                  shamt_n  = op_b[4:0];
                  is_ctz_n = (alu_ctl == OP_CTZ);
               end else begin
                  state_n = DONE;
                  res_n   = comb_op(alu_ctl, op_a, op_b);
               end
            end
         end
         BUSY: begin
            if (is_ctz) begin
               if (shadow[0] || count == 6'd32) begin
                  state_n = DONE;
                  res_n   = {{(WIDTH-6){1'b0}}, count};
               end else begin
                  shadow_n = shadow >> 1;
                  count_n  = count + 6'd1;
               end
            end else begin
               if (count == {1'b0, shamt}) begin
                  state_n = DONE;
                  res_n   = shadow;
               end else begin
                  shadow_n = shadow << 1;
                  count_n  = count + 6'd1;
               end
            end
         end
         DONE: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         shadow <= '0;
         res_q  <= '0;
         shamt  <= '0;
         is_ctz <= 1'b0;
      end else begin
         state  <= state_n;
         count  <= count_n;
         shadow <= shadow_n;
         res_q  <= res_n;
         shamt  <= shamt_n;
         is_ctz <= is_ctz_n;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign result    = res_q;
   assign zero      = (res_q == '0);

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; fixed at 32, no other value supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 alu_ctl  input  4  operation code from the ALU control decoder.
REQ-007 op_a  input  32  operand A.
REQ-008 op_b  input  32  operand B; op_b[4:0] is the shift amount for SLL.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  32  operation result.
REQ-012 zero  output  1  high when result == 0; drives branch decisions.

Function
REQ-013 Opcodes: 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1 or 0), 0001 OR, 0000 AND, 1000 SLL, 1010 CTZ of op_a; any other code yields result 0.
REQ-014 Arithmetic is modulo 2^32; no overflow/carry output.
REQ-015 States IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 Accept occurs on a rising edge with state IDLE and in_valid = 1; operands and alu_ctl are captured; later input changes have no effect.
REQ-017 Single-cycle ops (ADD, SUB, SLT, OR, AND, undefined): IDLE -> DONE on accept; out_valid high the following cycle (latency 1).
REQ-018 SLL: IDLE -> BUSY with count = 0, shadow = op_a; each BUSY cycle: if count == shamt, go DONE with result = shadow, else shadow <<= 1, count += 1; BUSY occupies shamt+1 cycles, latency shamt+2.
REQ-019 CTZ: IDLE -> BUSY with count = 0, shadow = op_a; each BUSY cycle: if shadow[0] == 1 or count == 32, go DONE with result = count, else shadow >>= 1 (logical), count += 1; op_a = 0 gives result 32 after 33 BUSY cycles.
REQ-020 count is 6 bits wide so it reaches 32 without wrap.
REQ-021 DONE holds result and zero stable until out_ready = 1; DONE -> IDLE on that edge.
REQ-022 No back-to-back accept: a new request is accepted no earlier than the cycle after the DONE -> IDLE transition.
REQ-023 out_ready while not in DONE is ignored; in_valid while not in IDLE is ignored and not queued.

Reset
REQ-024 rst = 1 at a rising edge forces IDLE, out_valid = 0, in_ready = 1 (next cycle), result = 0, zero = 1, count = 0, shadow = 0.
REQ-025 Reset mid-BUSY or in DONE abandons the operation; no result is delivered.
REQ-026 rst has priority over all handshakes in the same cycle.

Configuration
REQ-027 Macro ALU_ITER_FAST_SHIFT_EN: when defined, SLL is a single-cycle op (result = op_a << op_b[4:0], latency 1, never enters BUSY).
REQ-028 Without ALU_ITER_FAST_SHIFT_EN, SLL follows REQ-018; CTZ is iterative in both builds.

Verification
REQ-029 ADD 0x0000_0005 + 0x0000_0003, out_ready = 1 -> out_valid one cycle after accept, result 0x0000_0008, zero 0.
REQ-030 SUB 7 - 7 -> result 0, zero 1; SLT op_a = 0xFFFF_FFFF, op_b = 1 -> result 1.
REQ-031 SLL op_a = 0x1, op_b = 4, macro undefined -> result 0x10 after 6 cycles (5 BUSY); macro defined -> 0x10 after 1 cycle.
REQ-032 CTZ op_a = 0x0000_0100 -> result 8 after 10 cycles; op_a = 0 -> result 32 after 34 cycles.
REQ-033 Hold out_ready = 0 for 5 cycles in DONE -> result stable, in_ready 0, in_valid pulses ignored; out_ready = 1 -> IDLE next cycle.
REQ-034 Assert rst during CTZ BUSY of op_a = 0 -> next cycle IDLE, out_valid 0, result 0, zero 1; subsequent ADD completes normally.
